gb_cfg_axil_master: RTL and testbench
=====================================

// Module: gb_cfg_axil_master
// PURPOSE
//  AXI4-Lite initiator driving the s_axi_config slave of the gaussian hls_target (config addr 5b, data 32b).
//  Converts single-beat commands (write/read) from the test/eq harness into AW/W/B or AR/R transactions.
//  Returns one response per command: read data plus RESP, or write RESP.
//  Sits between the harness sequencer and hls_s_axi_config_* on the eq/sim top.
// PARAMETERS
//  C_S_AXI_CONFIG_ADDR_WIDTH   5     address width (matches hls_target config bus)
//  C_S_AXI_CONFIG_DATA_WIDTH   32    data width; WSTRB width = DATA_WIDTH/8
//  TIMEOUT_CYCLES              255   watchdog limit, used only with GB_CFG_TIMEOUT_EN
// PORTS
//  clk                  in   1    clock
//  rst                  in   1    synchronous reset, active-high
//  cmd_valid            in   1    command present
//  cmd_ready            out  1    command accepted when cmd_valid & cmd_ready
//  cmd_write            in   1    1 = write, 0 = read
//  cmd_addr             in   5    byte address
//  cmd_wdata            in   32   write data
//  cmd_wstrb            in   4    write byte strobes
//  rsp_valid            out  1    response present
//  rsp_ready            in   1    response consumed when rsp_valid & rsp_ready
//  rsp_rdata            out  32   read data (0 for writes)
//  rsp_resp             out  2    AXI RESP/BRESP; 2'b11 = local timeout (macro only)
//  m_axi_config_AWVALID/AWREADY/AWADDR[4:0]   out/in/out   write address channel
//  m_axi_config_WVALID/WREADY/WDATA[31:0]/WSTRB[3:0]   out/in/out/out   write data channel
//  m_axi_config_BVALID/BREADY/BRESP[1:0]   in/out/in   write response channel
//  m_axi_config_ARVALID/ARREADY/ARADDR[4:0]   out/in/out   read address channel
//  m_axi_config_RVALID/RREADY/RDATA[31:0]/RRESP[1:0]   in/out/in/in   read data channel
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_resp=0; all *VALID=0; BREADY=RREADY=0; addr/data regs 0.
//  FSM: IDLE -> WR (cmd_write) | RD (!cmd_write) on cmd accept; cmd_ready=1 only in IDLE; cmd fields registered at accept.
//  WR: AWVALID and WVALID asserted together the cycle after accept; each drops independently on its own handshake
//   (aw_done/w_done flags); AW/W order of acceptance arbitrary, incl. same cycle. Both done -> WRSP.
//  WRSP: BREADY=1; on BVALID capture BRESP, rsp_rdata=0 -> RSP.
//  RD: ARVALID=1 until ARREADY -> RDAT. RDAT: RREADY=1; on RVALID capture RDATA/RRESP -> RSP.
//  RSP: rsp_valid=1 held stable until rsp_ready -> IDLE (cmd_ready=1 next cycle; no back-to-back overlap).
//  VALID never deasserted before its READY; ADDR/DATA/STRB stable while VALID high (AXI rule).
//  Latency with zero-wait slave: accept T, AW/W T+1, B T+2, rsp_valid T+3.
//  Only one outstanding transaction; BREADY/RREADY never asserted outside WRSP/RDAT.
//  Non-OKAY RESP (SLVERR/DECERR) passed through unchanged; no retry.
//  rst mid-transaction: immediate return to reset values; harness must also reset the slave.
// CONFIGURATION
//  GB_CFG_TIMEOUT_EN defined: 8b counter clears on state entry, counts in WR/WRSP/RD/RDAT;
//   reaching TIMEOUT_CYCLES drops all VALID/READY, sets rsp_resp=2'b11, rsp_rdata=32'hDEAD_BEEF, -> RSP.
//  Undefined: no counter; FSM waits indefinitely on slave handshakes; rsp_resp only reflects slave.
// TESTING
//  write 0x00=0x0000_0001 strb 0xF, slave zero-wait -> AW/W same cycle T+1, rsp_valid T+3, resp 00.
//  read 0x00 after start, slave RDATA=0x0000_0004 -> rsp_rdata 0x0000_0004, resp 00, rsp_valid held 3 cycles under rsp_ready=0.
//  write with WREADY 4 cycles after AWREADY -> AWVALID drops at AW handshake, WVALID stays until WREADY; single B.
//  read with BRESP/RRESP=2'b10 -> rsp_resp 2'b10 passed through.
//  rst asserted while in RDAT -> next cycle ARVALID=RREADY=0, cmd_ready=1, rsp_valid=0.
//  GB_CFG_TIMEOUT_EN, ARREADY held 0 for 300 cycles -> rsp_resp 2'b11, rsp_rdata 0xDEADBEEF after 255 cycles.

Source files
------------

// File: rtl/gb_cfg_axil_master.sv
// gb_cfg_axil_master: single-outstanding AXI4-Lite initiator turning harness write/read commands into AW/W/B or AR/R transactions
module gb_cfg_axil_master #(
  parameter int C_S_AXI_CONFIG_ADDR_WIDTH = 5,
  parameter int C_S_AXI_CONFIG_DATA_WIDTH = 32
`ifdef GB_CFG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic                                   cmd_write,
  input  logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_S_AXI_CONFIG_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                             rsp_resp,
  output logic                                   m_axi_config_AWVALID,
  input  logic                                   m_axi_config_AWREADY,
  output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]   m_axi_config_AWADDR,
  output logic                                   m_axi_config_WVALID,
  input  logic                                   m_axi_config_WREADY,
  output logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]   m_axi_config_WDATA,
  output logic [C_S_AXI_CONFIG_DATA_WIDTH/8-1:0] m_axi_config_WSTRB,
  input  logic                                   m_axi_config_BVALID,
  output logic                                   m_axi_config_BREADY,
  input  logic [1:0]                             m_axi_config_BRESP,
  output logic                                   m_axi_config_ARVALID,
  input  logic                                   m_axi_config_ARREADY,
  output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]   m_axi_config_ARADDR,
  input  logic                                   m_axi_config_RVALID,
  output logic                                   m_axi_config_RREADY,
  input  logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]   m_axi_config_RDATA,
  input  logic [1:0]                             m_axi_config_RRESP
);
  localparam int AW = C_S_AXI_CONFIG_ADDR_WIDTH;
  localparam int DW = C_S_AXI_CONFIG_DATA_WIDTH;
  localparam int SW = DW / 8;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRSP, S_RD, S_RDAT, S_RSP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic busy, tmo;
  assign busy = state_q inside {S_WR, S_WRSP, S_RD, S_RDAT};
`ifdef GB_CFG_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign tmo = busy && cnt_q == 8'(TIMEOUT_CYCLES - 1);
  // cnt_q is zero on the first cycle of every wait state, so a stalled state lasts exactly TIMEOUT_CYCLES cycles
  assign cnt_d = (busy && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif
  // VALID/READY are squashed in the timeout cycle so no handshake can complete as the FSM bails out
  assign cmd_ready            = state_q == S_IDLE;
  assign rsp_valid            = state_q == S_RSP;
  assign rsp_rdata            = rdata_q;
  assign rsp_resp             = resp_q;
  assign m_axi_config_AWVALID = state_q == S_WR && !aw_done_q && !tmo;
  assign m_axi_config_WVALID  = state_q == S_WR && !w_done_q && !tmo;
  assign m_axi_config_BREADY  = state_q == S_WRSP && !tmo;
  assign m_axi_config_ARVALID = state_q == S_RD && !tmo;
  assign m_axi_config_RREADY  = state_q == S_RDAT && !tmo;
  assign m_axi_config_AWADDR  = addr_q;
  assign m_axi_config_ARADDR  = addr_q;
  assign m_axi_config_WDATA   = wdata_q;
  assign m_axi_config_WSTRB   = wstrb_q;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = cmd_write ? S_WR : S_RD;
      end
      S_WR: begin
        aw_done_d = aw_done_q | (m_axi_config_AWVALID & m_axi_config_AWREADY);
        w_done_d  = w_done_q | (m_axi_config_WVALID & m_axi_config_WREADY);
        state_d   = (aw_done_d && w_done_d) ? S_WRSP : S_WR;
      end
      S_WRSP: if (m_axi_config_BREADY && m_axi_config_BVALID) begin
        resp_d  = m_axi_config_BRESP;
        rdata_d = '0;
        state_d = S_RSP;
      end
      S_RD: state_d = (m_axi_config_ARVALID && m_axi_config_ARREADY) ? S_RDAT : S_RD;
      S_RDAT: if (m_axi_config_RREADY && m_axi_config_RVALID) begin
        resp_d  = m_axi_config_RRESP;
        rdata_d = m_axi_config_RDATA;
        state_d = S_RSP;
      end
      S_RSP: state_d = rsp_ready ? S_IDLE : S_RSP;
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      state_d = S_RSP;
      resp_d  = 2'b11;
      rdata_d = DW'(32'hDEAD_BEEF);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_gb_cfg_axil_master.sv
// tb_gb_cfg_axil_master: randomized self-checking bench with a delay-programmable AXI4-Lite slave and a word-memory reference model
module tb_gb_cfg_axil_master;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [4:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [4:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  gb_cfg_axil_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_config_AWVALID(awvalid), .m_axi_config_AWREADY(awready), .m_axi_config_AWADDR(awaddr),
    .m_axi_config_WVALID(wvalid), .m_axi_config_WREADY(wready), .m_axi_config_WDATA(wdata),
    .m_axi_config_WSTRB(wstrb), .m_axi_config_BVALID(bvalid), .m_axi_config_BREADY(bready),
    .m_axi_config_BRESP(bresp), .m_axi_config_ARVALID(arvalid), .m_axi_config_ARREADY(arready),
    .m_axi_config_ARADDR(araddr), .m_axi_config_RVALID(rvalid), .m_axi_config_RREADY(rready),
    .m_axi_config_RDATA(rdata), .m_axi_config_RRESP(rresp));
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 0, rresp_cfg = 0;
  logic aw_got = 0, w_got = 0, ar_got = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, b_count = 0;
  logic [4:0] s_awaddr = 0, s_araddr = 0;
  logic [31:0] s_wdata = 0;
  logic [3:0] s_wstrb = 0;
  logic [31:0] smem [8];
  logic [31:0] model_mem [8];
  assign awready = awvalid && !aw_got && aw_wait >= aw_dly;
  assign wready  = wvalid && !w_got && w_wait >= w_dly;
  assign bvalid  = aw_got && w_got && b_wait >= b_dly;
  assign bresp   = bresp_cfg;
  assign arready = arvalid && !ar_got && ar_wait >= ar_dly;
  assign rvalid  = ar_got && r_wait >= r_dly;
  assign rdata   = smem[s_araddr[4:2]];
  assign rresp   = rresp_cfg;
  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
    end else begin
      if (awvalid && awready) begin aw_got <= 1; s_awaddr <= awaddr; end
      else if (awvalid) aw_wait <= aw_wait + 1;
      if (wvalid && wready) begin w_got <= 1; s_wdata <= wdata; s_wstrb <= wstrb; end
      else if (wvalid) w_wait <= w_wait + 1;
      if (bvalid && bready) begin
        aw_got <= 0; w_got <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0; b_count <= b_count + 1;
        for (int i = 0; i < 4; i++) if (s_wstrb[i]) smem[s_awaddr[4:2]][8*i +: 8] <= s_wdata[8*i +: 8];
      end else if (aw_got && w_got) b_wait <= b_wait + 1;
      if (arvalid && arready) begin ar_got <= 1; s_araddr <= araddr; end
      else if (arvalid) ar_wait <= ar_wait + 1;
      if (rvalid && rready) begin ar_got <= 0; ar_wait <= 0; r_wait <= 0; end
      else if (ar_got) r_wait <= r_wait + 1;
    end
  end
  // AXI stability: a VALID not yet accepted must still be high with unchanged payload one cycle later
  logic mon_en = 1;
  logic p_aw = 0, p_w = 0, p_ar = 0;
  logic [4:0] p_awaddr = 0, p_araddr = 0;
  logic [35:0] p_wpay = 0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (p_aw) begin
        checks++;
        if (awvalid !== 1'b1 || awaddr !== p_awaddr) begin errors++; $display("FAIL aw_stable got valid=%b addr=%h want 1 %h", awvalid, awaddr, p_awaddr); end
      end
      if (p_w) begin
        checks++;
        if (wvalid !== 1'b1 || {wstrb, wdata} !== p_wpay) begin errors++; $display("FAIL w_stable got valid=%b pay=%h want 1 %h", wvalid, {wstrb, wdata}, p_wpay); end
      end
      if (p_ar) begin
        checks++;
        if (arvalid !== 1'b1 || araddr !== p_araddr) begin errors++; $display("FAIL ar_stable got valid=%b addr=%h want 1 %h", arvalid, araddr, p_araddr); end
      end
    end
    p_aw = mon_en && !rst && awvalid && !awready; p_awaddr = awaddr;
    p_w  = mon_en && !rst && wvalid && !wready;   p_wpay = {wstrb, wdata};
    p_ar = mon_en && !rst && arvalid && !arready; p_araddr = araddr;
  end
  int lat, aw_first, aw_last, w_first, w_last;
  task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [31:0] rd, output logic [1:0] rs);
    int guard = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && guard < 1000) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    cmd_valid = 0;
    lat = 1; aw_first = -1; aw_last = -1; w_first = -1; w_last = -1;
    while (!rsp_valid && lat < 2000) begin
      if (awvalid) begin if (aw_first < 0) aw_first = lat; aw_last = lat; end
      if (wvalid) begin if (w_first < 0) w_first = lat; w_last = lat; end
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_arrival got rsp_valid=%b want 1 within %0d cycles", rsp_valid, lat); end
    rd = rsp_rdata; rs = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs) begin
        errors++; $display("FAIL rsp_hold got valid=%b data=%h resp=%b want 1 %h %b", rsp_valid, rsp_rdata, rsp_resp, rd, rs);
      end
    end
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rsp_release got valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready); end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction
  task automatic pulse_reset();
    rst = 1; @(posedge clk); #1; @(posedge clk); #1; rst = 0;
  endtask
  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready} !== 7'b1000000 || rsp_rdata !== 0 || rsp_resp !== 0) begin
      errors++; $display("FAIL reset got ctl=%b data=%h resp=%b want 1000000 0 0", {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, rsp_rdata, rsp_resp);
    end
  endtask
  task automatic test_write_basic();
    logic [31:0] rd; logic [1:0] rs;
    do_cmd(1, 5'h00, 32'h0000_0001, 4'hF, 0, rd, rs);
    model_mem[0] = merge(model_mem[0], 32'h1, 4'hF);
    checks++;
    if (aw_first !== 1 || w_first !== 1 || lat !== 3) begin errors++; $display("FAIL write_timing got aw=%0d w=%0d rsp=%0d want 1 1 3", aw_first, w_first, lat); end
    checks++;
    if (rd !== 0 || rs !== 2'b00) begin errors++; $display("FAIL write_rsp got %h %b want 0 00", rd, rs); end
    checks++;
    if (smem[0] !== model_mem[0]) begin errors++; $display("FAIL write_mem got %h want %h", smem[0], model_mem[0]); end
  endtask
  task automatic test_read_basic();
    logic [31:0] rd; logic [1:0] rs;
    do_cmd(1, 5'h00, 32'h0000_0004, 4'hF, 0, rd, rs);
    model_mem[0] = merge(model_mem[0], 32'h4, 4'hF);
    do_cmd(0, 5'h00, 0, 0, 3, rd, rs);
    checks++;
    if (rd !== model_mem[0] || rs !== 2'b00 || lat !== 3) begin errors++; $display("FAIL read_basic got %h %b lat=%0d want %h 00 3", rd, rs, lat, model_mem[0]); end
  endtask
  task automatic test_w_delay();
    logic [31:0] rd; logic [1:0] rs;
    int b0 = b_count;
    aw_dly = 0; w_dly = 4;
    do_cmd(1, 5'h08, 32'hA5A5_1234, 4'hF, 0, rd, rs);
    model_mem[2] = merge(model_mem[2], 32'hA5A5_1234, 4'hF);
    w_dly = 0;
    checks++;
    if (aw_first !== 1 || aw_last !== 1 || w_first !== 1 || w_last !== 5 || lat !== 7) begin
      errors++; $display("FAIL w_delay got aw=%0d..%0d w=%0d..%0d rsp=%0d want 1..1 1..5 7", aw_first, aw_last, w_first, w_last, lat);
    end
    checks++;
    if (b_count - b0 !== 1 || smem[2] !== model_mem[2]) begin errors++; $display("FAIL single_b got b=%0d mem=%h want 1 %h", b_count - b0, smem[2], model_mem[2]); end
  endtask
  task automatic test_err_resp();
    logic [31:0] rd; logic [1:0] rs;
    bresp_cfg = 2'b10; rresp_cfg = 2'b10;
    do_cmd(1, 5'h0C, 32'h0BAD_0BAD, 4'h3, 1, rd, rs);
    model_mem[3] = merge(model_mem[3], 32'h0BAD_0BAD, 4'h3);
    checks++;
    if (rs !== 2'b10 || rd !== 0) begin errors++; $display("FAIL bresp_pass got %b %h want 10 0", rs, rd); end
    do_cmd(0, 5'h0C, 0, 0, 1, rd, rs);
    checks++;
    if (rs !== 2'b10 || rd !== model_mem[3]) begin errors++; $display("FAIL rresp_pass got %b %h want 10 %h", rs, rd, model_mem[3]); end
    bresp_cfg = 0; rresp_cfg = 0;
  endtask
  task automatic test_random();
    logic [31:0] rd, d; logic [1:0] rs, er; logic [4:0] a; logic [3:0] s; logic wr;
    for (int n = 0; n < 60; n++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      er = 2'($urandom_range(0, 3)); bresp_cfg = er; rresp_cfg = er;
      wr = 1'($urandom_range(0, 1)); a = 5'($urandom_range(0, 7) * 4); d = $urandom; s = 4'($urandom_range(0, 15));
      do_cmd(wr, a, d, s, $urandom_range(0, 2), rd, rs);
      if (wr) model_mem[a[4:2]] = merge(model_mem[a[4:2]], d, s);
      checks++;
      if (rd !== (wr ? 32'h0 : model_mem[a[4:2]]) || rs !== er) begin
        errors++; $display("FAIL random_%0d wr=%b addr=%h got %h %b want %h %b", n, wr, a, rd, rs, wr ? 32'h0 : model_mem[a[4:2]], er);
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bresp_cfg = 0; rresp_cfg = 0;
  endtask
  task automatic test_reset_mid();
    int guard = 0;
    r_dly = 10;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h08;
    @(posedge clk); #1; cmd_valid = 0;
    while (!rready && guard < 50) begin @(posedge clk); #1; guard++; end
    checks++;
    if (rready !== 1'b1) begin errors++; $display("FAIL reach_rdat got rready=%b want 1", rready); end
    rst = 1; @(posedge clk); #1; rst = 0;
    checks++;
    if ({arvalid, rready, cmd_ready, rsp_valid} !== 4'b0010 || rsp_rdata !== 0 || rsp_resp !== 0) begin
      errors++; $display("FAIL reset_mid got ar/r/cmd/rsp=%b data=%h resp=%b want 0010 0 0", {arvalid, rready, cmd_ready, rsp_valid}, rsp_rdata, rsp_resp);
    end
    r_dly = 0;
  endtask
  task automatic test_timeout();
`ifdef GB_CFG_TIMEOUT_EN
    logic [31:0] rd; logic [1:0] rs;
    mon_en = 0; ar_dly = 300;
    do_cmd(0, 5'h04, 0, 0, 0, rd, rs);
    checks++;
    if (rs !== 2'b11 || rd !== 32'hDEAD_BEEF || lat !== 256) begin errors++; $display("FAIL timeout got %b %h lat=%0d want 11 deadbeef 256", rs, rd, lat); end
    ar_dly = 0; pulse_reset(); mon_en = 1;
`endif
  endtask
  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] rs;
    for (int i = 0; i < 8; i++) begin
      do_cmd(1, 5'(i * 4), 32'h1111_1111 * i, 4'hF, 0, rd, rs);
      model_mem[i] = merge(model_mem[i], 32'h1111_1111 * i, 4'hF);
    end
    for (int i = 7; i >= 0; i--) begin
      do_cmd(0, 5'(i * 4), 0, 0, 0, rd, rs);
      checks++;
      if (rd !== model_mem[i] || rs !== 0) begin errors++; $display("FAIL b2b_read_%0d got %h %b want %h 00", i, rd, rs, model_mem[i]); end
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin smem[i] = 0; model_mem[i] = 0; end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_w_delay();
    test_err_resp();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
